spie_buf: RTL and testbench

Buffered SPI front-end between the CPU I/O bus and the `spie_rxtx` master engine. Holds a TX FIFO and an RX FIFO, a control register (chip selects, speed, byte order, data width), and a sequencer FSM. The FSM drains the TX FIFO word by word into `spie_rxtx` and pushes each received word into the RX FIFO. Software can queue a burst of transfers without polling `rdy` per word.

---
 rtl/spie_buf.sv | 254 +++++++++++++++++++++++++
 tb/tb_spie_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spie_buf.sv
// spie_buf -- buffered SPI front-end between the CPU I/O bus and the
// spie_rxtx master engine.
//
// A TX FIFO collects words written by software. A sequencer drains it one
// word at a time into spie_rxtx and pushes each received word into an RX
// FIFO. This lets software queue a burst of transfers without polling the
// engine between words.
//
// Optional feature macro: SPIE_BUF_RXDROP_EN
//   When defined, control bit 8 (rxdrop) is implemented. A transfer launched
//   with rxdrop set skips its RX push, so write-only bursts do not stall on a
//   full RX FIFO. When undefined, bit 8 is ignored and every transfer pushes.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   stb, we, addr    bus strobe, write enable, register select
//                    (0 = data, 1 = control/status)
//   data_in          bus write data
//   data_out         bus read data, combinational
//   cs_n             active-low chip selects, straight from the control register
//   spi_start        one-cycle start pulse to the engine
//   spi_fast, spi_msbytefirst, spi_datawidth, spi_data_tx
//                    per-transfer settings and word, latched at LOAD
//   spi_rdy          engine ready/done
//   spi_data_rx      word received by the engine
module spie_buf #(
  parameter int unsigned depth_log2 = 4,
  parameter int unsigned num_cs     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  input  logic              we,
  input  logic              addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [num_cs-1:0] cs_n,
  output logic              spi_start,
  output logic              spi_fast,
  output logic              spi_msbytefirst,
  output logic [1:0]        spi_datawidth,
  output logic [31:0]       spi_data_tx,
  input  logic              spi_rdy,
  input  logic [31:0]       spi_data_rx
);

  localparam int unsigned DEPTH = 2 ** depth_log2;
  localparam int unsigned CW    = depth_log2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_SKIP,
    ST_WAIT,
    ST_STORE
  } state_t;

  state_t state_q;

  // Control register
  logic [num_cs-1:0] ctrl_cs_q;
  logic              ctrl_fast_q;
  logic              ctrl_msb_q;
  logic [1:0]        ctrl_dw_q;
  logic              ctrl_rxdrop;
  logic              ovf_q;

  // Per-transfer latched settings
  logic              spi_start_q;
  logic              spi_fast_q;
  logic              spi_msb_q;
  logic [1:0]        spi_dw_q;
  logic [31:0]       spi_data_tx_q;
  logic              rxdrop_lat_q;

  // FIFO storage and pointers
  logic [31:0]           tx_mem_q [DEPTH];
  logic [31:0]           rx_mem_q [DEPTH];
  logic [depth_log2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [depth_log2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [depth_log2-1:0] rx_wr_addr;

  // Bus decode
  logic bus_wr_data, bus_wr_ctrl, bus_rd_data, fifo_clr;
  logic tx_full, tx_empty, rx_full, rx_empty, busy;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign bus_wr_data = stb & we & ~addr;
  assign bus_wr_ctrl = stb & we & addr;
  assign bus_rd_data = stb & ~we & ~addr;
  assign fifo_clr    = bus_wr_ctrl & data_in[9];

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign busy     = (state_q != ST_IDLE) | ~tx_empty;

  assign tx_push = bus_wr_data & ~tx_full;
  assign tx_pop  = (state_q == ST_LOAD) & ~tx_empty;
  assign rx_pop  = bus_rd_data & ~rx_empty;
  // A clear in the STORE cycle empties the RX FIFO first; the word then
  // lands at slot 0 of the freshly emptied FIFO.
  assign rx_push    = (state_q == ST_STORE) & ~rxdrop_lat_q & (fifo_clr | ~rx_full);
  assign rx_wr_addr = fifo_clr ? '0 : rx_wp_q;

`ifdef SPIE_BUF_RXDROP_EN
  logic ctrl_rxdrop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rxdrop_q <= 1'b0;
    end else if (bus_wr_ctrl) begin
      ctrl_rxdrop_q <= data_in[8];
    end
  end
  assign ctrl_rxdrop = ctrl_rxdrop_q;
`else
  assign ctrl_rxdrop = 1'b0;
`endif

  // Control register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_cs_q   <= '0;
      ctrl_fast_q <= 1'b0;
      ctrl_msb_q  <= 1'b0;
      ctrl_dw_q   <= 2'b00;
      ovf_q       <= 1'b0;
    end else if (bus_wr_ctrl) begin
      ctrl_cs_q   <= data_in[num_cs-1:0];
      ctrl_fast_q <= data_in[4];
      ctrl_msb_q  <= data_in[5];
      ctrl_dw_q   <= data_in[7:6];
      ovf_q       <= 1'b0;
    end else if (bus_wr_data && tx_full) begin
      ovf_q <= 1'b1;
    end
  end

  // FIFO pointer/count next state
  always_comb begin
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;

    if (fifo_clr) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_rp_d  = '0;
      rx_wp_d  = rx_push ? depth_log2'(1) : '0;
      rx_cnt_d = rx_push ? CW'(1) : '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

      if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // FIFO storage, no reset needed: contents are only visible via counts
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data_in;
    if (rx_push) rx_mem_q[rx_wr_addr] <= spi_data_rx;
  end

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      spi_start_q   <= 1'b0;
      spi_fast_q    <= 1'b0;
      spi_msb_q     <= 1'b0;
      spi_dw_q      <= 2'b00;
      spi_data_tx_q <= '0;
      rxdrop_lat_q  <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!tx_empty && !rx_full && spi_rdy) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          // A FIFO clear coinciding with the IDLE->LOAD step leaves nothing
          // to send; fall back to IDLE rather than launch a stale word.
          if (tx_empty) begin
            state_q <= ST_IDLE;
          end else begin
            spi_data_tx_q <= tx_mem_q[tx_rp_q];
            spi_fast_q    <= ctrl_fast_q;
            spi_msb_q     <= ctrl_msb_q;
            spi_dw_q      <= ctrl_dw_q;
            rxdrop_lat_q  <= ctrl_rxdrop;
            spi_start_q   <= 1'b1;
            state_q       <= ST_FIRE;
          end
        end
        ST_FIRE:  state_q <= ST_SKIP;
        // The engine's rdy is still high from the previous word here.
        ST_SKIP:  state_q <= ST_WAIT;
        ST_WAIT: begin
          if (spi_rdy) state_q <= ST_STORE;
        end
        ST_STORE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus read mux
  always_comb begin
    data_out = '0;
    if (addr) begin
      data_out = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 2'b00,
                  ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};
    end else if (!rx_empty) begin
      data_out = rx_mem_q[rx_rp_q];
    end
  end

  assign cs_n            = ~ctrl_cs_q;
  assign spi_start       = spi_start_q;
  assign spi_fast        = spi_fast_q;
  assign spi_msbytefirst = spi_msb_q;
  assign spi_datawidth   = spi_dw_q;
  assign spi_data_tx     = spi_data_tx_q;

endmodule

// File: tb/tb_spie_buf.sv
module tb_spie_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [2:0]  cs_n;
  logic        spi_start, spi_fast, spi_msbytefirst;
  logic [1:0]  spi_datawidth;
  logic [31:0] spi_data_tx;
  logic        spi_rdy;
  logic [31:0] spi_data_rx = '0;

  int n_checks = 0;
  int n_pass   = 0;

  spie_buf #(.depth_log2(4), .num_cs(3)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .cs_n(cs_n),
    .spi_start(spi_start), .spi_fast(spi_fast),
    .spi_msbytefirst(spi_msbytefirst), .spi_datawidth(spi_datawidth),
    .spi_data_tx(spi_data_tx), .spi_rdy(spi_rdy), .spi_data_rx(spi_data_rx)
  );

  always #5 clk = ~clk;

  // Engine model: rdy drops after a start, returns after eng_lat cycles
  // with the sent word looped back, zero-extended to the latched width.
  logic        eng_rdy_q = 1'b1;
  logic        eng_busy = 1'b0;
  logic        eng_hold = 1'b0;
  int          eng_lat = 3;
  int          eng_cnt = 0;
  logic [31:0] eng_tx = '0;
  logic [1:0]  eng_dw = 2'b00;
  int          start_cnt = 0;
  logic [1:0]  dw_log [0:63];

  assign spi_rdy = eng_rdy_q & ~eng_hold;

  function automatic logic [31:0] eng_mask(input logic [31:0] w, input logic [1:0] dw);
    case (dw)
      2'b00:   return {24'h0, w[7:0]};
      2'b10:   return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (spi_start) begin
      eng_busy   <= 1'b1;
      eng_rdy_q  <= 1'b0;
      eng_cnt    <= eng_lat;
      eng_tx     <= spi_data_tx;
      eng_dw     <= spi_datawidth;
      dw_log[start_cnt] <= spi_datawidth;
      start_cnt  <= start_cnt + 1;
    end else if (eng_busy && !eng_hold) begin
      if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
      end else begin
        eng_busy    <= 1'b0;
        eng_rdy_q   <= 1'b1;
        spi_data_rx <= eng_mask(eng_tx, eng_dw);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1 d = data_out;
    @(posedge clk); #1;
    stb = 1'b0; addr = 1'b0;
  endtask

  task automatic peek_status(output logic [31:0] s);
    addr = 1'b1;
    #1 s = data_out;
    addr = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_status(input string tag, input logic [31:0] exp, input int budget);
    logic [31:0] s;
    peek_status(s);
    for (int i = 0; i < budget && s !== exp; i++) begin
      step(1);
      peek_status(s);
    end
    check(tag, s, exp);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && start_cnt < n; i++) step(1);
    check(tag, start_cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    // Reset state
    step(3);
    rst = 1'b0;
    peek_status(r);
    check("reset_status", r, 32'h0000_0014);
    check("reset_cs_n", {29'h0, cs_n}, 32'h7);
    addr = 1'b0; #1;
    check("reset_data_out", data_out, 32'h0);
    check("reset_tx_regs", {spi_data_tx[31:4] | {26'h0, spi_datawidth}, spi_data_tx[3:0]}, 32'h0);
    check("reset_flags", {29'h0, spi_start, spi_fast, spi_msbytefirst}, 32'h0);
    step(5);
    check("reset_no_start", start_cnt, 0);

    // Single 8-bit transfer, launch timing and loopback
    bus_write(1'b1, 32'h0000_0001);
    check("cs0_selected", {29'h0, cs_n}, 32'h6);
    bus_write(1'b0, 32'hDEAD_BEA5);
    check("start_t0", {31'h0, spi_start}, 32'h0);
    step(1);
    check("start_t1", {31'h0, spi_start}, 32'h0);
    step(1);
    check("start_t2", {31'h0, spi_start}, 32'h1);
    check("width_8", {30'h0, spi_datawidth}, 32'h0);
    check("data_tx", spi_data_tx, 32'hDEAD_BEA5);
    step(1);
    check("start_t3", {31'h0, spi_start}, 32'h0);
    wait_status("rx_one", 32'h0000_0104, 60);
    check("one_start", start_cnt, 1);
    bus_read(1'b0, r);
    check("rx_word", r, 32'h0000_00A5);
    peek_status(r);
    check("rx_empty_after", r, 32'h0000_0014);
    bus_read(1'b0, r);
    check("empty_read", r, 32'h0);
    peek_status(r);
    check("empty_read_no_ovf", r, 32'h0000_0014);

    // TX overflow with engine stalled; pointers wrap
    eng_hold = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(1'b0, 32'h0000_0040 + i);
    peek_status(r);
    check("tx_full_ovf", r, 32'h0010_0033);
    bus_write(1'b1, 32'h0000_0001);
    peek_status(r);
    check("ovf_cleared", r, 32'h0010_0013);
    eng_hold = 1'b0;
    wait_status("rx_full", 32'h0000_100C, 600);
    check("starts_17", start_cnt, 17);

    // RX full blocks launches; one read frees exactly one slot
    for (int i = 0; i < 3; i++) bus_write(1'b0, 32'h0000_0080 + i);
    step(40);
    check("rx_full_blocks", start_cnt, 17);
    peek_status(r);
    check("blocked_status", r, 32'h0003_1009);
    bus_read(1'b0, r);
    check("rx_head", r, 32'h0000_0040);
    wait_starts("one_more_start", 18, 60);
    step(40);
    check("only_one_more", start_cnt, 18);
    peek_status(r);
    check("after_one_more", r, 32'h0002_1009);
    bus_write(1'b1, 32'h0000_0201);
    peek_status(r);
    check("fifo_clear", r, 32'h0000_0014);

    // Width change mid-transfer takes effect at the next LOAD
    eng_lat = 20;
    bus_write(1'b0, 32'h1122_3344);
    bus_write(1'b0, 32'h5566_7788);
    wait_starts("mid_first_start", 19, 60);
    bus_write(1'b1, 32'h0000_0041);
    check("width_held", {30'h0, spi_datawidth}, 32'h0);
    wait_starts("mid_second_start", 20, 100);
    check("dw_first", {30'h0, dw_log[18]}, 32'h0);
    check("dw_second", {30'h0, dw_log[19]}, 32'h1);
    wait_status("mid_rx_two", 32'h0000_0204, 100);
    bus_read(1'b0, r);
    check("mid_rx0", r, 32'h0000_0044);
    bus_read(1'b0, r);
    check("mid_rx1", r, 32'h5566_7788);
    eng_lat = 3;

    // rxdrop (bit 8): only honoured when the feature is built in
    bus_write(1'b1, 32'h0000_0101);
    for (int i = 0; i < 4; i++) bus_write(1'b0, 32'h0000_00F0 + i);
    wait_starts("rxdrop_starts", 24, 100);
`ifdef SPIE_BUF_RXDROP_EN
    wait_status("rxdrop_rx", 32'h0000_0014, 60);
`else
    wait_status("rxdrop_rx", 32'h0000_0404, 60);
`endif
    bus_write(1'b1, 32'h0000_0201);

    // Reset while waiting on the engine
    eng_lat = 20;
    bus_write(1'b1, 32'h0000_0007);
    check("cs_all", {29'h0, cs_n}, 32'h0);
    bus_write(1'b0, 32'hCAFE_F00D);
    wait_starts("wait_start", 25, 60);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    peek_status(r);
    check("rst_wait_status", r, 32'h0000_0014);
    check("rst_wait_cs_n", {29'h0, cs_n}, 32'h7);
    check("rst_wait_data_tx", spi_data_tx, 32'h0);
    step(40);
    peek_status(r);
    check("no_store_after_rst", r, 32'h0000_0014);
    check("no_relaunch", start_cnt, 25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
